// File: rtl/pipelined_adder_pkg.sv
// Shared constants, chunk-size helper and the per-stage payload carried down the adder pipeline.
package pipelined_adder_pkg;

    localparam int PA_DEFAULT_WIDTH  = 12;
    localparam int PA_DEFAULT_STAGES = 3;
    // Payload fields are sized for the widest supported adder; unused upper bits stay zero.
    localparam int PA_MAX_WIDTH      = 64;

    function automatic int pa_chunk(input int width, input int stages);
        return (stages > 0) ? (width / stages) : width;
    endfunction

    typedef struct packed {
        logic                    valid;
        logic                    carry;
        logic                    ovf;
        logic [PA_MAX_WIDTH-1:0] sum;
        logic [PA_MAX_WIDTH-1:0] a;
        logic [PA_MAX_WIDTH-1:0] b;
    } pa_stage_t;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell; the ripple chunks are built from these.
module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_s,
    output logic o_cout
);

    assign o_s    = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));

endmodule

// File: rtl/pipelined_adder_pipe_stage.sv
// One pipeline stage (module adder_pipe_stage): CHUNK-bit ripple add on its slice, registered with hold.
// The signed-overflow bit is produced here only when PIPELINED_ADDER_OVF_EN is defined.
module adder_pipe_stage
    import pipelined_adder_pkg::*;
#(
    parameter int WIDTH = PA_DEFAULT_WIDTH,
    parameter int CHUNK = pa_chunk(PA_DEFAULT_WIDTH, PA_DEFAULT_STAGES),
    parameter int IDX   = 0
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      i_advance,
    input  pa_stage_t i_pay,
    output pa_stage_t o_pay
);

    localparam int LO = IDX * CHUNK;

    logic [CHUNK:0]   w_c;
    logic [CHUNK-1:0] w_sum;
    pa_stage_t        w_next;
    pa_stage_t        r_pay;

    if (LO + CHUNK > WIDTH) begin : g_bad_slice
        $error("adder_pipe_stage: slice exceeds operand width");
    end

    assign w_c[0] = i_pay.carry;

    for (genvar j = 0; j < CHUNK; j++) begin : g_fa
        full_adder u_fa (
            .i_a    (i_pay.a[LO+j]),
            .i_b    (i_pay.b[LO+j]),
            .i_cin  (w_c[j]),
            .o_s    (w_sum[j]),
            .o_cout (w_c[j+1])
        );
    end

    // Consumed operand slices are zeroed so only the not-yet-added chunks travel onward.
    always_comb begin
        w_next                  = i_pay;
        w_next.carry            = w_c[CHUNK];
        w_next.sum[LO +: CHUNK] = w_sum;
        w_next.a[LO +: CHUNK]   = '0;
        w_next.b[LO +: CHUNK]   = '0;
`ifdef PIPELINED_ADDER_OVF_EN
        if (LO + CHUNK == WIDTH) begin
            w_next.ovf = (i_pay.a[WIDTH-1] == i_pay.b[WIDTH-1]) &&
                         (w_sum[CHUNK-1] != i_pay.a[WIDTH-1]);
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pay <= '0;
        end else if (i_advance) begin
            r_pay <= w_next;
        end
    end

    assign o_pay = r_pay;

endmodule

// File: rtl/pipelined_adder.sv
// STAGES-deep pipelined WIDTH-bit adder, S = A + B + CIN with carry-out in S[WIDTH].
// Optional OVF (two's-complement overflow) output when PIPELINED_ADDER_OVF_EN is defined.
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int WIDTH  = PA_DEFAULT_WIDTH,
    parameter int STAGES = PA_DEFAULT_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CIN,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH:0]   S,
    output logic             out_valid,
    input  logic             out_ready
`ifdef PIPELINED_ADDER_OVF_EN
    ,
    output logic             OVF
`endif
);

    localparam int CHUNK = pa_chunk(WIDTH, STAGES);

    if (WIDTH < 1 || STAGES < 1 || WIDTH > PA_MAX_WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_params
        $error("pipelined_adder: WIDTH must be >= 1, <= PA_MAX_WIDTH and a multiple of STAGES");
    end

    pa_stage_t w_pay_in;
    pa_stage_t w_pay_out [STAGES];
    pa_stage_t w_last;
    logic      w_advance;
    logic      w_unused_bits;

    // Handshake: a transfer happens on any edge where valid && ready. All stages move in
    // lockstep on w_advance; in_ready depends only on out_valid/out_ready, never on in_valid.
    assign w_last    = w_pay_out[STAGES-1];
    assign w_advance = !w_last.valid || out_ready;
    assign in_ready  = w_advance;

    always_comb begin
        w_pay_in       = '0;
        w_pay_in.valid = in_valid;
        w_pay_in.carry = CIN;
        w_pay_in.a     = PA_MAX_WIDTH'(A);
        w_pay_in.b     = PA_MAX_WIDTH'(B);
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        pa_stage_t w_in;
        if (k == 0) begin : g_first
            assign w_in = w_pay_in;
        end else begin : g_next
            assign w_in = w_pay_out[k-1];
        end

        adder_pipe_stage #(
            .WIDTH (WIDTH),
            .CHUNK (CHUNK),
            .IDX   (k)
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_advance (w_advance),
            .i_pay     (w_in),
            .o_pay     (w_pay_out[k])
        );
    end

    assign S         = {w_last.carry, w_last.sum[WIDTH-1:0]};
    assign out_valid = w_last.valid;
`ifdef PIPELINED_ADDER_OVF_EN
    assign OVF       = w_last.ovf;
`endif

    // Final-stage operand slices are all consumed; fold them away explicitly.
    assign w_unused_bits = ^{w_last.a, w_last.b, w_last.sum, w_last.ovf};

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed self-checking bench for pipelined_adder (WIDTH=12, STAGES=3).
// OVF vectors run only when PIPELINED_ADDER_OVF_EN is defined.
module tb_pipelined_adder;

    localparam int W = 12;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         in_valid;
    logic         in_ready;
    logic [W:0]   s;
    logic         out_valid;
    logic         out_ready;
`ifdef PIPELINED_ADDER_OVF_EN
    logic         ovf;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipelined_adder #(
        .WIDTH  (W),
        .STAGES (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .A         (a),
        .B         (b),
        .CIN       (cin),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .S         (s),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef PIPELINED_ADDER_OVF_EN
        ,
        .OVF       (ovf)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [W-1:0] ta, input logic [W-1:0] tb_in, input logic tc);
        in_valid = v;
        a        = ta;
        b        = tb_in;
        cin      = tc;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, '0, '0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_vec++;
        if (s !== 13'h0000) begin n_err++; $display("FAIL reset_s: got %h want 0000", s); end
        n_vec++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
`ifdef PIPELINED_ADDER_OVF_EN
        n_vec++;
        if (ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b want 0", ovf); end
`endif
        rst_n = 1'b1;
        tick();
        n_vec++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL post_reset_valid: got %b want 0", out_valid); end
    endtask

    task automatic test_latency_wrap();
        for (int t = 0; t < 5; t++) begin
            if (t == 0) drive(1'b1, 12'hFFF, 12'h001, 1'b0);
            else        drive(1'b0, '0, '0, 1'b0);
            #1;
            n_vec++;
            if (out_valid !== (t == 3)) begin
                n_err++; $display("FAIL lat_valid t=%0d: got %b want %b", t, out_valid, (t == 3));
            end
            if (t == 3) begin
                n_vec++;
                if (s !== 13'h1000) begin n_err++; $display("FAIL lat_sum: got %h want 1000", s); end
            end
            tick();
        end
    endtask

    task automatic test_streaming();
        logic [W:0] exp_s [8] = '{13'h0F0, 13'h202, 13'h312, 13'h424,
                                  13'h534, 13'h646, 13'h756, 13'h868};
        for (int t = 0; t < 12; t++) begin
            if (t < 8) drive(1'b1, W'(t * 32'h111), 12'h0F0, t[0]);
            else       drive(1'b0, '0, '0, 1'b0);
            #1;
            n_vec++;
            if (out_valid !== (t >= 3 && t < 11)) begin
                n_err++; $display("FAIL stream_valid t=%0d: got %b want %b", t, out_valid, (t >= 3 && t < 11));
            end
            if (t >= 3 && t < 11) begin
                n_vec++;
                if (s !== exp_s[t-3]) begin
                    n_err++; $display("FAIL stream_sum t=%0d: got %h want %h", t, s, exp_s[t-3]);
                end
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        logic       exp_v;
        logic       exp_rdy;
        logic [W:0] exp_s;
        for (int t = 0; t < 11; t++) begin
            case (t)
                0:       drive(1'b1, 12'h123, 12'h456, 1'b0);
                1:       drive(1'b1, 12'h100, 12'h001, 1'b0);
                2:       drive(1'b1, 12'h200, 12'h002, 1'b0);
                default: drive(1'b0, '0, '0, 1'b0);
            endcase
            out_ready = !(t >= 3 && t <= 6);
            #1;
            exp_v   = (t >= 3 && t <= 9);
            exp_rdy = !(t >= 3 && t <= 6);
            exp_s   = (t <= 7) ? 13'h579 : ((t == 8) ? 13'h101 : 13'h202);
            n_vec++;
            if (out_valid !== exp_v) begin
                n_err++; $display("FAIL bp_valid t=%0d: got %b want %b", t, out_valid, exp_v);
            end
            n_vec++;
            if (in_ready !== exp_rdy) begin
                n_err++; $display("FAIL bp_in_ready t=%0d: got %b want %b", t, in_ready, exp_rdy);
            end
            if (exp_v) begin
                n_vec++;
                if (s !== exp_s) begin n_err++; $display("FAIL bp_sum t=%0d: got %h want %h", t, s, exp_s); end
            end
            tick();
        end
        out_ready = 1'b1;
    endtask

    task automatic test_carry_in();
        for (int t = 0; t < 6; t++) begin
            case (t)
                0:       drive(1'b1, 12'hFFF, 12'hFFF, 1'b1);
                1:       drive(1'b1, 12'h000, 12'h000, 1'b1);
                default: drive(1'b0, '0, '0, 1'b0);
            endcase
            #1;
            n_vec++;
            if (out_valid !== (t == 3 || t == 4)) begin
                n_err++; $display("FAIL cin_valid t=%0d: got %b want %b", t, out_valid, (t == 3 || t == 4));
            end
            if (t == 3) begin
                n_vec++;
                if (s !== 13'h1FFF) begin n_err++; $display("FAIL cin_full: got %h want 1fff", s); end
            end
            if (t == 4) begin
                n_vec++;
                if (s !== 13'h0001) begin n_err++; $display("FAIL cin_zero: got %h want 0001", s); end
            end
            tick();
        end
    endtask

    task automatic test_reset_midflight();
        for (int t = 0; t < 3; t++) begin
            case (t)
                0:       drive(1'b1, 12'h010, 12'h020, 1'b0);
                1:       drive(1'b1, 12'h111, 12'h111, 1'b0);
                default: drive(1'b1, 12'h333, 12'h001, 1'b1);
            endcase
            tick();
        end
        drive(1'b0, '0, '0, 1'b0);
        #1;
        n_vec++;
        if (out_valid !== 1'b1 || s !== 13'h030) begin
            n_err++; $display("FAIL mid_pre_reset: got valid=%b s=%h want valid=1 s=030", out_valid, s);
        end
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_async_valid: got %b want 0", out_valid); end
        n_vec++;
        if (s !== 13'h0000) begin n_err++; $display("FAIL mid_async_s: got %h want 0000", s); end
        tick();
        tick();
        rst_n = 1'b1;
        for (int t = 0; t < 5; t++) begin
            #1;
            n_vec++;
            if (out_valid !== 1'b0) begin
                n_err++; $display("FAIL mid_after_release t=%0d: got %b want 0", t, out_valid);
            end
            tick();
        end
        for (int t = 0; t < 5; t++) begin
            if (t == 0) drive(1'b1, 12'h00A, 12'h005, 1'b0);
            else        drive(1'b0, '0, '0, 1'b0);
            #1;
            n_vec++;
            if (out_valid !== (t == 3)) begin
                n_err++; $display("FAIL mid_new_valid t=%0d: got %b want %b", t, out_valid, (t == 3));
            end
            if (t == 3) begin
                n_vec++;
                if (s !== 13'h00F) begin n_err++; $display("FAIL mid_new_sum: got %h want 00f", s); end
            end
            tick();
        end
    endtask

`ifdef PIPELINED_ADDER_OVF_EN
    task automatic test_ovf();
        for (int t = 0; t < 7; t++) begin
            case (t)
                0:       drive(1'b1, 12'h7FF, 12'h001, 1'b0);
                1:       drive(1'b1, 12'h800, 12'h800, 1'b0);
                2:       drive(1'b1, 12'h7FF, 12'h800, 1'b0);
                default: drive(1'b0, '0, '0, 1'b0);
            endcase
            #1;
            n_vec++;
            if (out_valid !== (t >= 3 && t <= 5)) begin
                n_err++; $display("FAIL ovf_valid t=%0d: got %b want %b", t, out_valid, (t >= 3 && t <= 5));
            end
            if (t == 3) begin
                n_vec++;
                if (ovf !== 1'b1 || s !== 13'h0800) begin
                    n_err++; $display("FAIL ovf_pos: got ovf=%b s=%h want ovf=1 s=0800", ovf, s);
                end
            end
            if (t == 4) begin
                n_vec++;
                if (ovf !== 1'b1 || s !== 13'h1000) begin
                    n_err++; $display("FAIL ovf_neg: got ovf=%b s=%h want ovf=1 s=1000", ovf, s);
                end
            end
            if (t == 5) begin
                n_vec++;
                if (ovf !== 1'b0 || s !== 13'h0FFF) begin
                    n_err++; $display("FAIL ovf_mixed: got ovf=%b s=%h want ovf=0 s=0fff", ovf, s);
                end
            end
            tick();
        end
    endtask
`endif

    initial begin
        test_reset();
        test_latency_wrap();
        test_streaming();
        test_backpressure();
        test_carry_in();
        test_reset_midflight();
`ifdef PIPELINED_ADDER_OVF_EN
        test_ovf();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
